// File: rtl/seq_mul_add.sv
// Shift-and-add multiplier with addend: result = a*b + addend, one multiplier bit per clock.
// Used to rebuild a dividend from (quotient, divisor, rest) and so cross-check the divider.
module seq_mul_add #(
  parameter int BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  input  logic [BITS-1:0]   addend,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] result
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_reg;
  logic [2*BITS-1:0]   acc_reg;
  logic [2*BITS-1:0]   mcand_reg;
  logic [BITS-1:0]     mplier_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [2*BITS-1:0]   result_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg    <= {{BITS{1'b0}}, addend};
            mcand_reg  <= {{BITS{1'b0}}, a};
            mplier_reg <= b;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          // Fixed BITS iterations regardless of b, so latency never depends on data.
          if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
          end
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            state_reg <= FINISH;
          end
        end
        FINISH: begin
          result_reg <= acc_reg;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed and exhaustive checks of seq_mul_add (BITS=4): latency, handshake, reset abort.
module tb_seq_mul_add;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] addend;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul_add #(.BITS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .addend (addend),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation at a falling edge and waits (bounded) for done.
  // done must appear at the 6th falling edge after start is raised, busy high on exactly 5 of them.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [3:0] tad,
                        input logic [7:0] expected, input string name, input bit check_timing);
    int k;
    int bcnt;
    k = 0;
    bcnt = 0;
    a = ta;
    b = tb_v;
    addend = tad;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        k = i;
        break;
      end
    end
    if (check_timing) begin
      n_checks++;
      if (k !== 6) begin
        n_fail++;
        $display("FAIL %s done_latency: got %0d cycles, expected 6", name, k);
      end
      n_checks++;
      if (bcnt !== 5) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d, expected 5", name, bcnt);
      end
    end
    n_checks++;
    if (result !== expected) begin
      n_fail++;
      $display("FAIL %s result: a=%0d b=%0d addend=%0d got %0d expected %0d",
               name, ta, tb_v, tad, result, expected);
    end
    $display("op %s: a=%0d b=%0d addend=%0d result=%0d expected=%0d", name, ta, tb_v, tad, result, expected);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    addend = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%0d expected 0 0 0", busy, done, result);
    end
    // rst and start together: rst must win
    start = 1'b1;
    a = 4'd3;
    b = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_beats_start: busy=%b expected 0", busy);
    end
    $display("reset: busy=%b done=%b result=%0d", busy, done, result);
  endtask

  task automatic test_basic();
    run_op(4'd13, 4'd11, 4'd0, 8'd143, "mul_13x11", 1'b1);
    run_op(4'd15, 4'd15, 4'd15, 8'd240, "max_operands", 1'b1);
    run_op(4'd3, 4'd4, 4'd2, 8'd14, "div_inverse", 1'b1);
    run_op(4'd0, 4'd9, 4'd7, 8'd7, "zero_mcand", 1'b1);
    run_op(4'd9, 4'd0, 4'd0, 8'd0, "zero_mplier", 1'b1);
  endtask

  task automatic test_hold();
    run_op(4'd6, 4'd7, 4'd1, 8'd43, "hold_setup", 1'b0);
    a = 4'd15;
    b = 4'd15;
    addend = 4'd15;
    repeat (8) @(negedge clk);
    n_checks++;
    if (result !== 8'd43 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL result_hold: result=%0d done=%b expected 43 0", result, done);
    end
    $display("hold: result=%0d", result);
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    int dones;
    first_done = 0;
    second_done = 0;
    dones = 0;
    a = 4'd2;
    b = 4'd3;
    addend = 4'd1;
    start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 4'd9;
        b = 4'd9;
        addend = 4'd9;
      end
      if (done) begin
        dones++;
        if (first_done == 0) begin
          first_done = i;
          n_checks++;
          if (result !== 8'd7 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: result=%0d busy=%b expected 7 0", result, busy);
          end
        end else if (second_done == 0) begin
          second_done = i;
          n_checks++;
          if (result !== 8'd90) begin
            n_fail++;
            $display("FAIL b2b_second: result=%0d expected 90", result);
          end
        end
      end
      if (i == 7) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_restart: busy=%b expected 1", busy);
        end
        start = 1'b0;
      end
    end
    n_checks++;
    if (first_done !== 6 || second_done !== 12 || dones !== 2) begin
      n_fail++;
      $display("FAIL b2b_done_timing: first=%0d second=%0d count=%0d expected 6 12 2",
               first_done, second_done, dones);
    end
    $display("back_to_back: first_done=%0d second_done=%0d dones=%0d", first_done, second_done, dones);
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    a = 4'd7;
    b = 4'd7;
    addend = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || result !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_async: busy=%b result=%0d expected 0 0", busy, result);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: dones=%0d busy=%b expected 0 0", dones, busy);
    end
    $display("abort: dones=%0d busy=%b result=%0d", dones, busy, result);
    run_op(4'd5, 4'd5, 4'd0, 8'd25, "after_abort", 1'b1);
  endtask

  task automatic test_sweep();
    int k;
    logic [7:0] expected;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 16; ic++) begin
          expected = 8'(ia * ib + ic);
          a = 4'(ia);
          b = 4'(ib);
          addend = 4'(ic);
          start = 1'b1;
          k = 0;
          for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin
              k = i;
              break;
            end
          end
          n_checks++;
          if (k !== 6 || result !== expected) begin
            n_fail++;
            $display("FAIL sweep: a=%0d b=%0d addend=%0d result=%0d latency=%0d expected %0d latency 6",
                     ia, ib, ic, result, k, expected);
          end
        end
      end
    end
    $display("sweep: 4096 operations checked");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
